note_sprite_blitter: RTL



---
 rtl/note_sprite_blitter.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/note_sprite_blitter.sv
// Note sprite blitter: walks a SPR_W x SPR_H ROM sprite and emits clipped framebuffer writes.
// Optional macro BLIT_OPAQUE_EN: write every unclipped pixel (0 pixels clear to background).
`timescale 1ns/1ps
module note_sprite_blitter #(
   parameter int unsigned SPR_W    = 40,
   parameter int unsigned SPR_H    = 45,
   parameter int unsigned ROM_LAT  = 2,
   parameter int unsigned SCREEN_W = 640,
   parameter int unsigned SCREEN_H = 480
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start_valid,
   output logic        start_ready,
   input  logic [9:0]  x0,
   input  logic [8:0]  y0,
   input  logic [5:0]  note_type,
   output logic [14:0] rom_addr,
   output logic [5:0]  rom_note_type,
   input  logic        rom_pixel,
   output logic        fb_we,
   output logic [9:0]  fb_x,
   output logic [8:0]  fb_y,
   output logic        fb_data,
   output logic        done
);
   localparam int unsigned ColW = $clog2(SPR_W);
   localparam int unsigned RowW = $clog2(SPR_H);
   localparam int unsigned CntW = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;
   localparam logic [14:0] LastAddr = 15'(SPR_W * SPR_H - 1);

   typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

   state_e                         state_q, state_d;
   logic [9:0]                     x0_q, x0_d;
   logic [8:0]                     y0_q, y0_d;
   logic [5:0]                     note_q, note_d;
   logic [14:0]                    addr_q, addr_d;
   logic [ColW-1:0]                col_q, col_d;
   logic [RowW-1:0]                row_q, row_d;
   logic [CntW-1:0]                drain_q, drain_d;
   logic [ROM_LAT-1:0]             dl_valid_q, dl_valid_d;
   logic [ROM_LAT-1:0][ColW-1:0]   dl_col_q, dl_col_d;
   logic [ROM_LAT-1:0][RowW-1:0]   dl_row_q, dl_row_d;
   logic                           xfer;
   logic                           last_addr;
   logic [10:0]                    sum_x;
   logic [9:0]                     sum_y;
   logic                           clipped;

   assign xfer      = (state_q == StIdle) && start_valid;
   assign last_addr = (addr_q == LastAddr);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (start_valid) state_d = StIssue;
         StIssue: if (last_addr) state_d = StDrain;
         StDrain: if (drain_q == CntW'(ROM_LAT - 1)) state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      x0_d    = x0_q;
      y0_d    = y0_q;
      note_d  = note_q;
      addr_d  = addr_q;
      col_d   = col_q;
      row_d   = row_q;
      drain_d = '0;
      if (xfer) begin
         x0_d   = x0;
         y0_d   = y0;
         note_d = note_type;
         addr_d = '0;
         col_d  = '0;
         row_d  = '0;
      end else if (state_q == StIssue && !last_addr) begin
         addr_d = addr_q + 15'd1;
         if (col_q == ColW'(SPR_W - 1)) begin
            col_d = '0;
            row_d = row_q + RowW'(1);
         end else begin
            col_d = col_q + ColW'(1);
         end
      end else if (state_q == StDrain) begin
         drain_d = drain_q + CntW'(1);
      end
      // Coordinates ride alongside the ROM so they line up with rom_pixel.
      dl_valid_d[0] = (state_q == StIssue);
      dl_col_d[0]   = col_q;
      dl_row_d[0]   = row_q;
      for (int unsigned i = 1; i < ROM_LAT; i++) begin
         dl_valid_d[i] = dl_valid_q[i-1];
         dl_col_d[i]   = dl_col_q[i-1];
         dl_row_d[i]   = dl_row_q[i-1];
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         x0_q       <= '0;
         y0_q       <= '0;
         note_q     <= '0;
         addr_q     <= '0;
         col_q      <= '0;
         row_q      <= '0;
         drain_q    <= '0;
         dl_valid_q <= '0;
         dl_col_q   <= '0;
         dl_row_q   <= '0;
      end else begin
         x0_q       <= x0_d;
         y0_q       <= y0_d;
         note_q     <= note_d;
         addr_q     <= addr_d;
         col_q      <= col_d;
         row_q      <= row_d;
         drain_q    <= drain_d;
         dl_valid_q <= dl_valid_d;
         dl_col_q   <= dl_col_d;
         dl_row_q   <= dl_row_d;
      end
   end

   // Sums are one bit wider than the outputs so off-screen positions cannot wrap back on.
   assign sum_x   = {1'b0, x0_q} + 11'(dl_col_q[ROM_LAT-1]);
   assign sum_y   = {1'b0, y0_q} + 10'(dl_row_q[ROM_LAT-1]);
   assign clipped = (sum_x >= 11'(SCREEN_W)) || (sum_y >= 10'(SCREEN_H));

   always_comb begin
      start_ready   = (state_q == StIdle);
      done          = (state_q == StDone);
      rom_addr      = addr_q;
      rom_note_type = note_q;
      fb_x          = sum_x[9:0];
      fb_y          = sum_y[8:0];
`ifdef BLIT_OPAQUE_EN
      fb_we         = dl_valid_q[ROM_LAT-1] && !clipped;
      fb_data       = dl_valid_q[ROM_LAT-1] && rom_pixel;
`else
      fb_we         = dl_valid_q[ROM_LAT-1] && rom_pixel && !clipped;
      fb_data       = fb_we;
`endif
   end

endmodule
